// File: rtl/demux2_reg_pkg.sv
// demux2_reg_pkg: slot state encoding, branch indices and selected-branch ready helper.
package demux2_reg_pkg;

    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL  = 1'b1;
    localparam logic BR0        = 1'b0;
    localparam logic BR1        = 1'b1;

    typedef enum logic {
        S_EMPTY = SLOT_EMPTY,
        S_FULL  = SLOT_FULL
    } slot_e;

    // A branch can take a word when its slot is empty or is draining this cycle.
    function automatic logic sel_ready(
        input logic sel,
        input logic v0,
        input logic r0,
        input logic v1,
        input logic r1
    );
        return (sel == BR1) ? (!v1 || r1) : (!v0 || r0);
    endfunction

endpackage

// File: rtl/demux2_reg_slot.sv
// demux_slot: one-entry output slot (EMPTY/FULL) with valid/ready drain and same-cycle refill.
module demux_slot
    import demux2_reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             fill,
    input  logic [WIDTH-1:0] fill_data,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data
);

    slot_e state;
    slot_e state_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_EMPTY;
            data  <= '0;
        end else begin
            state <= state_nxt;
            if (fill)
                data <= fill_data;
        end
    end

    // Fill wins over drain so a simultaneous drain+fill stays FULL with the new word.
    always_comb begin
        state_nxt = fill ? S_FULL : ((state == S_FULL) && ready) ? S_EMPTY : state;
    end

    assign valid = (state == S_FULL);

endmodule

// File: rtl/demux2_reg.sv
// demux2_reg: registered 1-to-2 valid/ready demultiplexer, one cycle latency.
// Optional per-branch handshake counters cnt0/cnt1 when DEMUX2_CNT_EN is defined.
module demux2_reg
    import demux2_reg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX2_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("demux2_reg: CNT_W must be at least 1");
    end

    logic accept;
    logic fill0;
    logic fill1;

    assign in_ready = resetn && sel_ready(in_sel, out0_valid, out0_ready, out1_valid, out1_ready);
    assign accept   = in_valid && in_ready;
    assign fill0    = accept && (in_sel == BR0);
    assign fill1    = accept && (in_sel == BR1);

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .resetn    (resetn),
        .fill      (fill0),
        .fill_data (in_data),
        .valid     (out0_valid),
        .ready     (out0_ready),
        .data      (out0_data)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .resetn    (resetn),
        .fill      (fill1),
        .fill_data (in_data),
        .valid     (out1_valid),
        .ready     (out1_ready),
        .data      (out1_data)
    );

`ifdef DEMUX2_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready)
                cnt0 <= cnt0 + 1'b1;
            if (out1_valid && out1_ready)
                cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux2_reg.sv
// tb_demux2_reg: directed checks of steering, backpressure, independence, drain+fill and async reset.
module tb_demux2_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
`ifdef DEMUX2_CNT_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
`endif

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux2_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX2_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_v0", 32'(out0_valid), 32'h0);
        check("rst_v1", 32'(out1_valid), 32'h0);
        check("rst_d0", out0_data, 32'h0);
        check("rst_d1", out1_data, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Steering
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h11);
        check("steer_ready_a", 32'(in_ready), 32'h1);
        tick();
        check("steer_v0_a", 32'(out0_valid), 32'h1);
        check("steer_d0_a", out0_data, 32'h11);
        check("steer_v1_a", 32'(out1_valid), 32'h0);
        drive(1'b1, 1'b1, 32'h22);
        tick();
        check("steer_v1_b", 32'(out1_valid), 32'h1);
        check("steer_d1_b", out1_data, 32'h22);
        check("steer_v0_b", 32'(out0_valid), 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        check("steer_idle_v0", 32'(out0_valid), 32'h0);
        check("steer_idle_v1", 32'(out1_valid), 32'h0);

        // Backpressure
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h33);
        tick();
        check("bp_v0", 32'(out0_valid), 32'h1);
        check("bp_d0", out0_data, 32'h33);
        drive(1'b1, 1'b0, 32'h44);
        check("bp_stall", 32'(in_ready), 32'h0);
        tick();
        check("bp_hold_v0", 32'(out0_valid), 32'h1);
        check("bp_hold_d0", out0_data, 32'h33);
        out0_ready = 1'b1;
        #1;
        check("bp_release", 32'(in_ready), 32'h1);
        tick();
        check("bp_next_v0", 32'(out0_valid), 32'h1);
        check("bp_next_d0", out0_data, 32'h44);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        check("bp_drained", 32'(out0_valid), 32'h0);

        // Independent branches
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h77);
        tick();
        drive(1'b1, 1'b1, 32'h55);
        check("ind_ready", 32'(in_ready), 32'h1);
        tick();
        check("ind_v1", 32'(out1_valid), 32'h1);
        check("ind_d1", out1_data, 32'h55);
        check("ind_d0", out0_data, 32'h77);
        drive(1'b1, 1'b0, 32'h99);
        check("ind_sel_change", 32'(in_ready), 32'h0);

        // Simultaneous drain and fill on branch 1
        out1_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h66);
        check("df_ready", 32'(in_ready), 32'h1);
        tick();
        check("df_v1", 32'(out1_valid), 32'h1);
        check("df_d1", out1_data, 32'h66);
        check("df_v0_hold", 32'(out0_valid), 32'h1);
        drive(1'b0, 1'b0, 32'h0);
        tick();
        check("df_v1_drained", 32'(out1_valid), 32'h0);

        // Async reset mid-transfer
        out0_ready = 1'b1;
        tick();
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        check("ar_d0_before", out0_data, 32'hDEAD_BEEF);
        #1;
        resetn = 1'b0;
        #1;
        check("ar_v0", 32'(out0_valid), 32'h0);
        check("ar_d0", out0_data, 32'h0);
        check("ar_in_ready", 32'(in_ready), 32'h0);
`ifdef DEMUX2_CNT_EN
        check("ar_cnt0", 32'(cnt0), 32'h0);
`endif
        @(negedge clk);
        resetn = 1'b1;

`ifdef DEMUX2_CNT_EN
        // 17 handshakes on branch 0 wrap a 4-bit counter to 1
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 32'(i));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0);
        tick();
        check("cnt0_wrap", 32'(cnt0), 32'h1);
        check("cnt1_zero", 32'(cnt1), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
